hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for a five-stage in-order core. It produces the
// pipeline register write enables and bubble (flush) controls for the current
// cycle, and keeps two saturating performance counters.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous reset, active low
//   id_rs1/rs2   : source register indices of the instruction in ID
//   id_uses_rs1/2: the ID instruction actually reads that source
//   ex_valid     : EX holds a valid instruction
//   ex_is_load   : the EX instruction is a load
//   ex_rd        : destination register of the EX instruction
//   ex_br_taken  : the EX branch/jump redirects the PC this cycle
//   imem_resp    : instruction cache delivers the fetch word this cycle
//   mem_dreq     : MEM holds a data access
//   dmem_resp    : data cache completes that access this cycle
//   cnt_clr      : synchronous clear of both performance counters
//   load_*       : pipeline register write enables (PC, IF/ID, ID/EX, EX/MEM,
//                  MEM/WB)
//   flush_if_id  : write a NOP bubble into IF/ID (only meaningful with load)
//   flush_id_ex  : write a NOP bubble into ID/EX (only meaningful with load)
//   state        : registered controller state, for observation only
//   stall_cnt    : cycles in which the PC was held (saturating)
//   flush_cnt    : taken-redirect flush events (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             imem_resp,
    input  logic             mem_dreq,
    input  logic             dmem_resp,
    input  logic             cnt_clr,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        IWAIT  = 2'd2,
        BUBBLE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state_q;
    state_t state_d;
    logic   stall_d;
    logic   stall_i;
    logic   lu;
    logic   flush_evt;

    // Hazard terms. A load writing x0 never creates a dependency.
    assign stall_d = mem_dreq & ~dmem_resp;
    assign stall_i = ~imem_resp;
    assign lu      = ex_valid & ex_is_load & (ex_rd != 5'd0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                      (id_uses_rs2 & (id_rs2 == ex_rd)));

    // Priority decode of the pipeline controls. Everything here depends only
    // on the current inputs; the registered state is never fed back, so a
    // held redirect during an I-miss is kept alive by EX itself being frozen.
    // Reset forces every enable and flush low.
    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        flush_evt   = 1'b0;
        state_d     = RUN;
        if (rst) begin
            if (stall_d) begin
                state_d = DWAIT;
            end else if (stall_i && ex_br_taken) begin
                state_d = IWAIT;
            end else if (ex_br_taken) begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                flush_evt   = 1'b1;
                state_d     = RUN;
            end else if (lu) begin
                // Freeze the front end one cycle and inject a bubble behind
                // the load; the load moves on so the hazard clears itself.
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                flush_id_ex = 1'b1;
                state_d     = BUBBLE;
            end else if (stall_i) begin
                // Hold the PC but let the back end drain; IF/ID takes a NOP.
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                flush_if_id = 1'b1;
                state_d     = IWAIT;
            end else begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
                state_d     = RUN;
            end
        end
    end

    // Observation-only state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // Saturating counters; a clear request wins over any increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!load_pc && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_evt && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed, table-driven bench for hazard_ctrl. A default-width instance and a
// CNT_W = 2 instance share all inputs; the narrow one exercises saturation.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_br_taken;
    logic        imem_resp;
    logic        mem_dreq;
    logic        dmem_resp;
    logic        cnt_clr;

    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb;
    logic        s_flush_if_id, s_flush_id_ex;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    logic [6:0]  ctrl;
    logic [6:0]  s_ctrl;

    int total;
    int bad;
    int exp_stall;
    int exp_flush;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exv;
        logic       exl;
        logic [4:0] rd;
        logic       br;
        logic       imem;
        logic       dreq;
        logic       dresp;
        logic [6:0] exp_ctrl;
        logic [1:0] exp_state;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
    localparam logic [6:0] C_RUN    = 7'b11111_00;
    localparam logic [6:0] C_FLUSH  = 7'b11111_11;
    localparam logic [6:0] C_BUBBLE = 7'b00111_01;
    localparam logic [6:0] C_IMISS  = 7'b01111_10;
    localparam logic [6:0] C_HOLD   = 7'b00000_00;

    assign ctrl   = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                     flush_if_id, flush_id_ex};
    assign s_ctrl = {s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb,
                     s_flush_if_id, s_flush_id_ex};

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_br_taken(ex_br_taken), .imem_resp(imem_resp),
        .mem_dreq(mem_dreq), .dmem_resp(dmem_resp), .cnt_clr(cnt_clr),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_br_taken(ex_br_taken), .imem_resp(imem_resp),
        .mem_dreq(mem_dreq), .dmem_resp(dmem_resp), .cnt_clr(cnt_clr),
        .load_pc(s_load_pc), .load_if_id(s_load_if_id), .load_id_ex(s_load_id_ex),
        .load_ex_mem(s_load_ex_mem), .load_mem_wb(s_load_mem_wb),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .state(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2,
                                input logic exv, input logic exl, input logic [4:0] rd,
                                input logic br, input logic imem,
                                input logic dreq, input logic dresp,
                                input logic [6:0] ec, input logic [1:0] es);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.exv = exv; v.exl = exl; v.rd = rd; v.br = br; v.imem = imem;
        v.dreq = dreq; v.dresp = dresp; v.exp_ctrl = ec; v.exp_state = es;
        return v;
    endfunction

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic applyStimulus(input vec_t v);
        id_rs1      = v.rs1;
        id_rs2      = v.rs2;
        id_uses_rs1 = v.u1;
        id_uses_rs2 = v.u2;
        ex_valid    = v.exv;
        ex_is_load  = v.exl;
        ex_rd       = v.rd;
        ex_br_taken = v.br;
        imem_resp   = v.imem;
        mem_dreq    = v.dreq;
        dmem_resp   = v.dresp;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the combinational controls mid-cycle, update the counter model,
    // then check the state captured at the following edge.
    task automatic cycleCheck(input string name, input logic [6:0] ec, input logic [1:0] es);
        @(negedge clk);
        checkOutput({name, ".ctrl"}, {25'd0, ctrl}, {25'd0, ec});
        checkOutput({name, ".sat_ctrl"}, {25'd0, s_ctrl}, {25'd0, ec});
        if (!ec[6]) exp_stall++;
        if (ec == C_FLUSH) exp_flush++;
        step();
        checkOutput({name, ".state"}, {30'd0, state}, {30'd0, es});
    endtask

    task automatic checkCounters(input string name);
        checkOutput({name, ".stall_cnt"}, stall_cnt, exp_stall);
        checkOutput({name, ".flush_cnt"}, flush_cnt, exp_flush);
        checkOutput({name, ".sat_stall"}, {30'd0, s_stall_cnt}, sat3(exp_stall));
        checkOutput({name, ".sat_flush"}, {30'd0, s_flush_cnt}, sat3(exp_flush));
    endtask

    task automatic clearCounters();
        cnt_clr = 1'b1;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RUN, 2'd0));
        step();
        cnt_clr   = 1'b0;
        exp_stall = 0;
        exp_flush = 0;
        checkCounters("clear");
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_stall = 0;
        exp_flush = 0;
        cnt_clr = 1'b0;

        // rs1, rs2, u1, u2, exv, exl, rd, br, imem, dreq, dresp, ctrl, state
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_RUN,    2'd0);
        vecs[1]  = mk(0, 5, 0, 1, 1, 1, 5, 0, 1, 0, 0, C_BUBBLE, 2'd3);
        vecs[2]  = mk(0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, C_RUN,    2'd0);
        vecs[3]  = mk(7, 3, 1, 0, 1, 1, 7, 0, 1, 0, 0, C_BUBBLE, 2'd3);
        vecs[4]  = mk(7, 3, 0, 1, 1, 1, 7, 0, 1, 0, 0, C_RUN,    2'd0);
        vecs[5]  = mk(7, 7, 1, 1, 1, 0, 7, 0, 1, 0, 0, C_RUN,    2'd0);
        vecs[6]  = mk(7, 7, 1, 1, 0, 1, 7, 0, 1, 0, 0, C_RUN,    2'd0);
        vecs[7]  = mk(0, 0, 0, 0, 1, 0, 4, 1, 1, 0, 0, C_FLUSH,  2'd0);
        vecs[8]  = mk(9, 0, 1, 0, 1, 1, 9, 1, 1, 0, 0, C_FLUSH,  2'd0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IMISS,  2'd2);
        vecs[10] = mk(0, 0, 0, 0, 1, 0, 4, 1, 0, 0, 0, C_HOLD,   2'd2);
        vecs[11] = mk(0, 5, 0, 1, 1, 1, 5, 0, 0, 0, 0, C_BUBBLE, 2'd3);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_HOLD,   2'd1);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_RUN,    2'd0);
        vecs[14] = mk(0, 5, 0, 1, 1, 1, 5, 1, 0, 1, 0, C_HOLD,   2'd1);

        // Reset: controls forced low even with ready caches and a load-use.
        rst = 1'b0;
        applyStimulus(mk(0, 5, 0, 1, 1, 1, 5, 0, 1, 0, 0, C_RUN, 2'd0));
        #2;
        checkOutput("reset.ctrl", {25'd0, ctrl}, 32'd0);
        checkOutput("reset.state", {30'd0, state}, 32'd0);
        checkCounters("reset");
        #10;
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            cycleCheck($sformatf("vec%0d", i), vecs[i].exp_ctrl, vecs[i].exp_state);
        end
        checkCounters("table");

        // Load-use bubble lasts one cycle, then the load has left EX.
        clearCounters();
        applyStimulus(mk(0, 5, 0, 1, 1, 1, 5, 0, 1, 0, 0, C_BUBBLE, 2'd3));
        cycleCheck("lu", C_BUBBLE, 2'd3);
        applyStimulus(mk(0, 5, 0, 1, 0, 0, 0, 0, 1, 0, 0, C_RUN, 2'd0));
        cycleCheck("lu_after", C_RUN, 2'd0);
        checkCounters("lu");

        // Data miss for three cycles hides a load-use and a branch.
        clearCounters();
        applyStimulus(mk(0, 5, 0, 1, 1, 1, 5, 1, 1, 1, 0, C_HOLD, 2'd1));
        for (int i = 0; i < 3; i++) cycleCheck($sformatf("dmiss%0d", i), C_HOLD, 2'd1);
        checkCounters("dmiss");
        applyStimulus(mk(0, 5, 0, 1, 1, 1, 5, 0, 1, 1, 1, C_BUBBLE, 2'd3));
        cycleCheck("dmiss_done", C_BUBBLE, 2'd3);
        checkCounters("dmiss_done");

        // Branch while the fetch misses: held, then flushed once.
        clearCounters();
        applyStimulus(mk(0, 0, 0, 0, 1, 0, 4, 1, 0, 0, 0, C_HOLD, 2'd2));
        for (int i = 0; i < 2; i++) cycleCheck($sformatf("brmiss%0d", i), C_HOLD, 2'd2);
        applyStimulus(mk(0, 0, 0, 0, 1, 0, 4, 1, 1, 0, 0, C_FLUSH, 2'd0));
        cycleCheck("br_redirect", C_FLUSH, 2'd0);
        checkCounters("br");

        // Reset asserted mid data miss takes effect immediately.
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_HOLD, 2'd1));
        cycleCheck("pre_rst0", C_HOLD, 2'd1);
        cycleCheck("pre_rst1", C_HOLD, 2'd1);
        rst = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        checkOutput("rst_mid.ctrl", {25'd0, ctrl}, 32'd0);
        checkOutput("rst_mid.state", {30'd0, state}, 32'd0);
        checkCounters("rst_mid");
        #2;
        rst = 1'b1;
        applyStimulus(mk(0, 5, 0, 1, 1, 1, 5, 0, 1, 0, 0, C_BUBBLE, 2'd3));
        cycleCheck("post_rst", C_BUBBLE, 2'd3);

        // Saturation of the narrow counter, then clear.
        clearCounters();
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_IMISS, 2'd2));
        for (int i = 0; i < 5; i++) cycleCheck($sformatf("sat%0d", i), C_IMISS, 2'd2);
        checkOutput("sat.stall_cnt", stall_cnt, 32'd5);
        checkOutput("sat.sat_stall", {30'd0, s_stall_cnt}, 32'd3);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        checkOutput("clr.stall_cnt", stall_cnt, 32'd0);
        checkOutput("clr.sat_stall", {30'd0, s_stall_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
